// File: rtl/lif_neuron_bank.sv
// lif_neuron_bank
//   Time-multiplexed bank of NUM_NEURONS signed leaky integrate-and-fire
//   neurons. One shared leak/integrate/saturate/fire datapath updates one
//   neuron per cycle. A start/busy/done handshake runs one sweep over the
//   whole bank for each timestep.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               request one sweep; ignored while busy
//   current_in          packed signed input current, neuron k at [k*WIDTH +: WIDTH]
//   threshold           signed firing threshold shared by the bank (<=0 disables firing)
//   decay               unsigned leak magnitude shared by the bank
//   refractory_period   refractory length in sweeps
//   busy                high from the first RUN cycle through the DONE cycle
//   done                one-cycle pulse at the end of a sweep
//   spikes_out          spike vector of the last completed sweep
//   dbg_sel             neuron index to observe
//   dbg_membrane        registered membrane of neuron dbg_sel (combinational read)

module lif_neuron_bank #(
    parameter int WIDTH       = 8,
    parameter int NUM_NEURONS = 4,
    parameter int REF_WIDTH   = 4,
    parameter int IDX_WIDTH   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_NEURONS*WIDTH-1:0] current_in,
    input  logic [WIDTH-1:0]             threshold,
    input  logic [WIDTH-1:0]             decay,
    input  logic [REF_WIDTH-1:0]         refractory_period,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_NEURONS-1:0]       spikes_out,
    input  logic [IDX_WIDTH-1:0]         dbg_sel,
    output logic [WIDTH-1:0]             dbg_membrane
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int EW = WIDTH + 2;
    localparam logic signed [EW-1:0] SAT_MAX = EW'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] SAT_MIN = EW'(-(2 ** (WIDTH - 1)));
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

    state_t                         state;
    logic [IDX_WIDTH-1:0]           idx;

    // Shadow copies of the sweep parameters, frozen when start is accepted.
    logic [NUM_NEURONS*WIDTH-1:0]   current_sh;
    logic [WIDTH-1:0]               threshold_sh;
    logic [WIDTH-1:0]               decay_sh;
    logic [REF_WIDTH-1:0]           ref_period_sh;

    logic signed [WIDTH-1:0]        membrane [NUM_NEURONS];
    logic [REF_WIDTH-1:0]           ref_cnt  [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]         spike_acc;

    logic signed [WIDTH-1:0]        v_cur;
    logic signed [WIDTH-1:0]        i_cur;
    logic signed [EW-1:0]           v_ext;
    logic signed [EW-1:0]           i_ext;
    logic signed [EW-1:0]           dec_ext;
    logic signed [EW-1:0]           thr_ext;
    logic signed [EW-1:0]           leak_tmp;
    logic signed [EW-1:0]           leaked;
    logic signed [EW-1:0]           sum;
    logic signed [EW-1:0]           sat;
    logic signed [WIDTH-1:0]        v_next;
    logic                           fire;
    logic                           refractory;
    logic [NUM_NEURONS-1:0]         spike_vec_next;

    // Shared datapath for the neuron selected by idx. Two guard bits keep the
    // leak and the sum exact before saturation back to WIDTH.
    always_comb begin
        v_cur    = membrane[idx];
        i_cur    = current_sh[idx*WIDTH +: WIDTH];
        v_ext    = EW'(v_cur);
        i_ext    = EW'(i_cur);
        dec_ext  = signed'({2'b00, decay_sh});
        thr_ext  = EW'(signed'(threshold_sh));
        leak_tmp = '0;
        leaked   = '0;

        // Leak toward zero but never past it.
        if (v_ext > 0) begin
            leak_tmp = v_ext - dec_ext;
            leaked   = (leak_tmp < 0) ? '0 : leak_tmp;
        end else if (v_ext < 0) begin
            leak_tmp = v_ext + dec_ext;
            leaked   = (leak_tmp > 0) ? '0 : leak_tmp;
        end

        sum = leaked + i_ext;
        if (sum > SAT_MAX) begin
            sat = SAT_MAX;
        end else if (sum < SAT_MIN) begin
            sat = SAT_MIN;
        end else begin
            sat = sum;
        end

        refractory = (ref_cnt[idx] != '0);
        fire       = !refractory && (thr_ext > 0) && (sat >= thr_ext);
        v_next     = fire ? WIDTH'(sat - thr_ext) : WIDTH'(sat);

        spike_vec_next      = spike_acc;
        spike_vec_next[idx] = fire;
    end

    // Sweep sequencer plus per-neuron state update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            spikes_out    <= '0;
            spike_acc     <= '0;
            current_sh    <= '0;
            threshold_sh  <= '0;
            decay_sh      <= '0;
            ref_period_sh <= '0;
            for (int k = 0; k < NUM_NEURONS; k++) begin
                membrane[k] <= '0;
                ref_cnt[k]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        current_sh    <= current_in;
                        threshold_sh  <= threshold;
                        decay_sh      <= decay;
                        ref_period_sh <= refractory_period;
                        idx           <= '0;
                        spike_acc     <= '0;
                        busy          <= 1'b1;
                        state         <= RUN;
                    end
                end

                RUN: begin
                    if (refractory) begin
                        ref_cnt[idx] <= ref_cnt[idx] - 1'b1;
                    end else begin
                        membrane[idx] <= v_next;
                        if (fire) begin
                            ref_cnt[idx] <= ref_period_sh;
                        end
                    end
                    spike_acc <= spike_vec_next;

                    // The last neuron's spike is folded in here so spikes_out
                    // is valid in the same cycle as done.
                    if (idx == LAST_IDX) begin
                        spikes_out <= spike_vec_next;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Out-of-range selections read as zero when NUM_NEURONS is not a power of two.
    always_comb begin
        dbg_membrane = '0;
        if (int'(dbg_sel) < NUM_NEURONS) begin
            dbg_membrane = membrane[dbg_sel];
        end
    end

endmodule
